// File: rtl/grey_convert_pipe.sv
// Pipelined RGB-to-grey converter: average / weighted luma / max / green modes,
// valid/ready backpressure, pixel counter. Optional binary output via GREY_THRESH_EN.
module grey_convert_pipe #(
   parameter int DW = 12,
   parameter int WF = 8,
   parameter int CW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_r,
   input  logic [DW-1:0] in_g,
   input  logic [DW-1:0] in_b,
   input  logic [1:0]    mode,
   input  logic [WF:0]   wt_r,
   input  logic [WF:0]   wt_g,
   input  logic [WF:0]   wt_b,
`ifdef GREY_THRESH_EN
   input  logic [DW-1:0] thresh,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_grey,
   output logic [CW-1:0] pix_count,
   input  logic          cnt_clr
);

   localparam int PW = DW + WF + 1;
   localparam int SW = DW + WF + 3;
   localparam int AW = DW + 2;
   localparam logic [SW-1:0] RND = SW'(1) << (WF - 1);

   // Handshake: a transfer happens on a cycle where valid && ready are both high.
   // Each stage loads when empty or when the stage after it is moving, so
   // bubbles collapse; out_ready reaches in_ready combinationally.
   logic v1, v2, v3;
   logic adv1, adv2, adv3;

   assign adv3      = !v3 || out_ready;
   assign adv2      = !v2 || adv3;
   assign adv1      = !v1 || adv2;
   assign in_ready  = adv1;
   assign out_valid = v3;

   // S1: products and per-mode selection
   logic [DW-1:0] mx_rg, mx_rgb;
   logic [AW-1:0] sel_d;
   logic [PW-1:0] pr_d, pg_d, pb_d;

   always_comb begin
      mx_rg  = (in_r > in_g) ? in_r : in_g;
      mx_rgb = (mx_rg > in_b) ? mx_rg : in_b;
      case (mode)
         2'd0:    sel_d = AW'(in_r) + AW'(in_g) + AW'(in_b);
         2'd2:    sel_d = AW'(mx_rgb);
         default: sel_d = AW'(in_g);
      endcase
      pr_d = PW'(wt_r) * PW'(in_r);
      pg_d = PW'(wt_g) * PW'(in_g);
      pb_d = PW'(wt_b) * PW'(in_b);
   end

   logic [1:0]    m1;
   logic [AW-1:0] sel1;
   logic [PW-1:0] pr1, pg1, pb1;
`ifdef GREY_THRESH_EN
   logic [DW-1:0] th1, th2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         m1   <= '0;
         sel1 <= '0;
         pr1  <= '0;
         pg1  <= '0;
         pb1  <= '0;
`ifdef GREY_THRESH_EN
         th1  <= '0;
`endif
      end else if (adv1) begin
         v1   <= in_valid;
         m1   <= mode;
         sel1 <= sel_d;
         pr1  <= pr_d;
         pg1  <= pg_d;
         pb1  <= pb_d;
`ifdef GREY_THRESH_EN
         th1  <= thresh;
`endif
      end
   end

   // S2: luma sum with rounding offset; the 3-way sum is divided here
   logic [1:0]    m2;
   logic [DW-1:0] a2;
   logic [SW-1:0] acc2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2   <= 1'b0;
         m2   <= '0;
         a2   <= '0;
         acc2 <= '0;
`ifdef GREY_THRESH_EN
         th2  <= '0;
`endif
      end else if (adv2) begin
         v2   <= v1;
         m2   <= m1;
         a2   <= (m1 == 2'd0) ? DW'(sel1 / AW'(3)) : sel1[DW-1:0];
         acc2 <= SW'(pr1) + SW'(pg1) + SW'(pb1) + RND;
`ifdef GREY_THRESH_EN
         th2  <= th1;
`endif
      end
   end

   // S3: drop fraction, saturate, pick result
   logic [SW-1:0] shf;
   logic [DW-1:0] luma3, grey3, res3;

   always_comb begin
      shf   = acc2 >> WF;
      luma3 = (|shf[SW-1:DW]) ? '1 : shf[DW-1:0];
      grey3 = (m2 == 2'd1) ? luma3 : a2;
      res3  = grey3;
`ifdef GREY_THRESH_EN
      res3  = (grey3 >= th2) ? '1 : '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3       <= 1'b0;
         out_grey <= '0;
      end else if (adv3) begin
         v3 <= v2;
         if (v2) out_grey <= res3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 pix_count <= '0;
      else if (cnt_clr)           pix_count <= '0;
      else if (v3 && out_ready)   pix_count <= pix_count + CW'(1);
   end

endmodule

// File: doc/grey_convert_pipe.md
Name: grey_convert_pipe

Overview:
- Parametrised, pipelined RGB-to-greyscale converter for the VGA/camera pixel path.
- Sits between the colour pixel source and the frame buffer/VGA writer.
- Extends the fixed average-only, single-register converter with:
  - selectable conversion modes and programmable luma weights;
  - rounding and saturation;
  - valid/ready backpressure;
  - a processed-pixel counter.

Parameters:
- DW, 12, colour channel and grey output width in bits.
- WF, 8, fractional bits of the luma weights; weight inputs are WF+1 bits wide (range 0..2^(WF+1)-1).
- CW, 24, width of the processed-pixel counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  converter can accept a pixel this cycle.
- in_r  in  DW  red channel.
- in_g  in  DW  green channel.
- in_b  in  DW  blue channel.
- mode  in  2  conversion mode; sampled with each accepted pixel.
- wt_r  in  WF+1  red weight; sampled with each accepted pixel.
- wt_g  in  WF+1  green weight; sampled with each accepted pixel.
- wt_b  in  WF+1  blue weight; sampled with each accepted pixel.
- out_valid  out  1  output grey valid.
- out_ready  in  1  downstream accepts output.
- out_grey  out  DW  grey result.
- pix_count  out  CW  number of pixels delivered (out_valid && out_ready).
- cnt_clr  in  1  synchronous clear of pix_count.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline:
  - 3 stages; S1 = multiply/select, S2 = sum, S3 = round/saturate/register.
  - Latency is exactly 3 cycles from input transfer to out_valid when no stall occurs.
  - Throughput is 1 pixel per clock.
- Per-stage valid bits v1, v2, v3; out_valid = v3.
  - Stage k advances when !v_k || advance_{k+1}; S3 advances when !v3 || out_ready.
  - in_ready = !v1 || S2 can advance. Bubbles collapse.
  - The combinational path out_ready -> in_ready is permitted.
- Stalled stages hold data and valid unchanged. No pixel is dropped, duplicated or reordered.
- mode and weights travel with the pixel. Changing them mid-stream affects only pixels accepted after the change.
- Modes:
  - 0 = exact average: floor((r+g+b)/3), computed with a DW+2 bit sum. Division is exact over the full input range; no saturation is needed.
  - 1 = weighted luma: (wt_r*r + wt_g*g + wt_b*b + 2^(WF-1)) >> WF. Intermediate width is DW+WF+3. The result saturates to 2^DW-1 if it exceeds DW bits.
  - 2 = max(r,g,b).
  - 3 = pass-through of green channel.
- pix_count:
  - Increments on each output transfer and wraps to 0 after 2^CW-1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Reset (asynchronous, any time including mid-stream):
  - v1..v3 = 0, out_valid = 0, out_grey = 0, pix_count = 0.
  - in_ready = 1 in the first cycle after release.
  - In-flight pixels are discarded.
- Data registers of stages with valid = 0 are don't-care, except out_grey, which holds its last value.

Optional Feature:
- Macro GREY_THRESH_EN.
- When defined:
  - Adds input port thresh [DW-1:0].
  - S3 output becomes binary: 2^DW-1 if the computed grey >= thresh, else 0.
  - thresh is sampled at input transfer and travels with the pixel.
  - Latency is unchanged.
- When undefined:
  - No thresh port exists.
  - Output is the raw computed grey.

Test Plan:
- Mode 0, DW=12: (r,g,b) = (4095,4095,4094) -> out_grey 4094 after 3 cycles; (1,1,0) -> 0; (3,3,3) -> 3.
- Mode 1, weights 77/150/29, r=g=b=4095 -> 4095. Weights 255/255/255, r=g=b=4095 -> saturates to 4095. Weights 77/150/29, (100,200,50) -> (7700+30000+1450+128)>>8 = 153.
- Modes 2/3: (10,300,20) -> mode 2 gives 300, mode 3 gives 300; (500,7,9) -> mode 2 gives 500, mode 3 gives 7.
- Backpressure:
  - Stream 8 pixels at in_valid=1 with out_ready=0 -> in_ready falls after exactly 3 accepts.
  - Release out_ready -> all 8 delivered in order, back-to-back, with no loss.
  - pix_count = 8; asserting cnt_clr together with a transfer leaves it at 0.
- Mid-stream mode change: pixels A (mode 0) and B (mode 2) on consecutive cycles -> A computed as average, B as max.
- Reset mid-stream: assert rst_n=0 with 3 pixels in flight -> out_valid drops immediately; after release no stale pixel appears and pix_count = 0.
- GREY_THRESH_EN build: thresh = 2048, grey 2047 -> 0, grey 2048 -> 4095.
